pipe_stage_skid: RTL
====================

# pipe_stage_skid

Parametrised, elastic pipeline register for the MIPS CPU datapath: the next generation of the fixed-field inter-stage latches. It carries an opcode field plus an opaque payload between two stages. A valid/ready handshake on each side replaces the single write enable, and a two-entry skid buffer keeps every output registered, including upstream ready. A flush kills in-flight work by converting it to the NOP opcode, and a saturating counter records downstream back-pressure cycles.

## Interface
Parameters:
- DATA_W, 32: payload width (alu result, valB, target, rd, control bits packed by the instantiator)
- OP_W, 6: opcode field width
- NOP_OP, 6'b111111: opcode presented whenever the stage holds no valid instruction
- CNT_W, 16: stall counter width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- i_valid  in  1  upstream presents an instruction
- o_in_ready  out  1  stage can accept (registered)
- i_op  in  OP_W  upstream opcode
- i_data  in  DATA_W  upstream payload
- o_valid  out  1  downstream instruction valid
- i_out_ready  in  1  downstream accepts
- o_op  out  OP_W  opcode (NOP_OP when o_valid=0)
- o_data  out  DATA_W  payload of main entry
- i_flush  in  1  synchronous kill of both entries
- i_cnt_clr  in  1  synchronous clear of stall counter
- o_stall_cnt  out  CNT_W  saturating count of back-pressured cycles

## Operation
- Transfers: in_fire = i_valid & o_in_ready & !i_flush; out_fire = o_valid & i_out_ready.
- Storage: main entry (drives outputs) and skid entry. Each entry holds op, data and a valid bit.
- States: EMPTY (no entry valid), BUSY (main valid, skid empty), FULL (both valid).
- EMPTY: in_fire -> main<=input, BUSY.
- BUSY, in_fire & out_fire: main<=input, stay BUSY.
- BUSY, in_fire only: skid<=input, FULL.
- BUSY, out_fire only: EMPTY.
- BUSY, neither: hold.
- FULL: out_fire -> main<=skid, BUSY. Otherwise hold. No input is accepted because o_in_ready=0.
- o_in_ready = (next state != FULL), registered, so it never depends combinationally on i_out_ready.
- Flush has priority over every transfer. Next state is EMPTY, both entry valids clear, and main op and data load NOP_OP and 0. A concurrent upstream instruction is dropped. A concurrent out_fire still counts as consumed downstream.
- When o_valid=0, o_op is forced to NOP_OP. o_data holds the last main contents (0 after reset or flush).
- Stall counter:
  - increments by 1 each cycle with o_valid & !i_out_ready;
  - saturates at 2^CNT_W-1;
  - i_cnt_clr clears it and takes priority over increment;
  - flush does not affect it.
- Data passes through unmodified; no width conversion; the op field is never altered except for NOP forcing.

## Timing
- Reset (asynchronous, immediate): o_valid=0, o_op=NOP_OP, o_data=0, o_in_ready=1, o_stall_cnt=0, state EMPTY.
- Latency: an accepted input appears on the outputs the next rising edge when the main entry is free or is being drained the same cycle.
- Throughput: 1 instruction/cycle sustained with i_out_ready held high.
- Back-pressure: the first stalled cycle still accepts one instruction into the skid entry. o_in_ready drops the following cycle and rises the cycle after the first out_fire from FULL.
- Order: strictly FIFO. The skid entry always leaves after the main entry.
- Reset mid-transfer discards both entries; no partial output.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset then stream ops 0x01..0x05 with i_valid=1 and i_out_ready=1 -> o_valid high from cycle 1, ops emerge 0x01..0x05 on consecutive cycles, o_in_ready stays 1, o_stall_cnt=0.
- Main holds 0x01, drive i_out_ready=0 for 3 cycles while offering 0x02, 0x03 -> 0x02 captured in skid, o_in_ready=0 from next cycle, 0x03 held upstream, o_stall_cnt=3. Release ready -> order 0x01, 0x02, 0x03 with no loss or duplication.
- FULL state plus i_flush=1 with i_valid=1 (op 0x09) -> next cycle o_valid=0, o_op=6'b111111, o_data=0, o_in_ready=1, 0x09 never appears.
- Assert rst asynchronously mid-stream between edges -> outputs go to reset values immediately, without waiting for a clock edge.
- CNT_W=4 with i_out_ready=0 and o_valid=1 for 20 cycles -> o_stall_cnt saturates at 15. i_cnt_clr with a concurrent stall -> 0.
- Random valid/ready toggling for 10k cycles against a reference queue model -> output sequence matches input, and o_op=NOP_OP whenever o_valid=0.

Source files
------------

// File: rtl/pipe_stage_skid_if.sv
// pipe_stage_skid_if
// Bundles the handshake, payload and control signals of one elastic
// pipeline stage so the stage and its neighbours connect through a
// single port.
//   i_valid / o_in_ready / i_op / i_data : upstream side of the stage
//   o_valid / i_out_ready / o_op / o_data : downstream side of the stage
//   i_flush                               : kill everything in flight
//   i_cnt_clr / o_stall_cnt               : back-pressure statistics
// Modports:
//   slave  - the stage itself
//   master - whoever drives the stage (neighbouring logic or a bench)
interface pipe_stage_skid_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 6,
  parameter int CNT_W  = 16
);
  logic              i_valid;
  logic              o_in_ready;
  logic [OP_W-1:0]   i_op;
  logic [DATA_W-1:0] i_data;
  logic              o_valid;
  logic              i_out_ready;
  logic [OP_W-1:0]   o_op;
  logic [DATA_W-1:0] o_data;
  logic              i_flush;
  logic              i_cnt_clr;
  logic [CNT_W-1:0]  o_stall_cnt;

  modport slave (
    input  i_valid, i_op, i_data, i_out_ready, i_flush, i_cnt_clr,
    output o_in_ready, o_valid, o_op, o_data, o_stall_cnt
  );

  modport master (
    output i_valid, i_op, i_data, i_out_ready, i_flush, i_cnt_clr,
    input  o_in_ready, o_valid, o_op, o_data, o_stall_cnt
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
// Elastic inter-stage register for the MIPS datapath. Carries an opcode
// and an opaque payload through a two-entry skid buffer so that every
// output, upstream ready included, comes straight from a flop.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset
//   bus  - pipe_stage_skid_if.slave: upstream valid/ready/op/data,
//          downstream valid/ready/op/data, flush, stall counter clear
//          and stall counter output
// Parameters:
//   DATA_W - payload width, OP_W - opcode width,
//   NOP_OP - opcode shown while no instruction is held,
//   CNT_W  - width of the saturating stall counter
module pipe_stage_skid #(
  parameter int              DATA_W = 32,
  parameter int              OP_W   = 6,
  parameter logic [OP_W-1:0] NOP_OP = 6'b111111,
  parameter int              CNT_W  = 16
) (
  input logic                clk,
  input logic                rst,
  pipe_stage_skid_if.slave   bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  // What the main entry loads on the coming edge.
  typedef enum logic [2:0] {
    MAIN_HOLD  = 3'd0,
    MAIN_IN    = 3'd1,
    MAIN_SKID  = 3'd2,
    MAIN_DRAIN = 3'd3,
    MAIN_FLUSH = 3'd4
  } main_sel_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state;
  state_t            state_next;
  main_sel_t         main_sel;
  logic              skid_load;
  logic              in_fire;
  logic              out_fire;

  logic [OP_W-1:0]   main_op;
  logic [DATA_W-1:0] main_data;
  logic [OP_W-1:0]   skid_op;
  logic [DATA_W-1:0] skid_data;
  logic              out_valid_q;
  logic              in_ready_q;
  logic [CNT_W-1:0]  stall_cnt;

  // Next-state and entry-load decisions. A flush overrides every transfer;
  // a concurrent out_fire needs no action because the entry is discarded
  // anyway, and a concurrent upstream instruction is simply not taken.
  always_comb begin
    state_next = state;
    main_sel   = MAIN_HOLD;
    skid_load  = 1'b0;
    in_fire    = bus.i_valid & in_ready_q & ~bus.i_flush;
    out_fire   = out_valid_q & bus.i_out_ready;

    if (bus.i_flush) begin
      state_next = EMPTY;
      main_sel   = MAIN_FLUSH;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            state_next = BUSY;
            main_sel   = MAIN_IN;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_sel = MAIN_IN;
          end else if (in_fire) begin
            state_next = FULL;
            skid_load  = 1'b1;
          end else if (out_fire) begin
            state_next = EMPTY;
            main_sel   = MAIN_DRAIN;
          end
        end
        FULL: begin
          // in_ready_q is low here, so nothing can enter.
          if (out_fire) begin
            state_next = BUSY;
            main_sel   = MAIN_SKID;
          end
        end
        default: begin
          state_next = EMPTY;
          main_sel   = MAIN_FLUSH;
        end
      endcase
    end
  end

  // State register plus the registered handshake outputs, which are
  // computed from the next state so they are valid right after the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state       <= state_next;
      out_valid_q <= (state_next != EMPTY);
      in_ready_q  <= (state_next != FULL);
    end
  end

  // Main entry. Draining the last instruction swaps in the NOP opcode but
  // keeps the payload, so o_op needs no output mux and o_data keeps
  // showing the last main contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_op   <= NOP_OP;
      main_data <= '0;
    end else begin
      unique case (main_sel)
        MAIN_IN: begin
          main_op   <= bus.i_op;
          main_data <= bus.i_data;
        end
        MAIN_SKID: begin
          main_op   <= skid_op;
          main_data <= skid_data;
        end
        MAIN_DRAIN: begin
          main_op   <= NOP_OP;
        end
        MAIN_FLUSH: begin
          main_op   <= NOP_OP;
          main_data <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  // Skid entry; its valid bit is the FULL state itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_op   <= '0;
      skid_data <= '0;
    end else if (skid_load) begin
      skid_op   <= bus.i_op;
      skid_data <= bus.i_data;
    end
  end

  // Saturating count of cycles where downstream refused a valid output.
  // Clear beats increment; flush leaves the count alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (bus.i_cnt_clr) begin
      stall_cnt <= '0;
    end else if (out_valid_q && !bus.i_out_ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  assign bus.o_valid     = out_valid_q;
  assign bus.o_in_ready  = in_ready_q;
  assign bus.o_op        = main_op;
  assign bus.o_data      = main_data;
  assign bus.o_stall_cnt = stall_cnt;

endmodule
